// File: rtl/hc283_seq_adder.sv
// hc283_seq_adder
//   Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit
//   carry-lookahead slice (74HC283 style). One nibble is processed per
//   clock, LSB nibble first, with a registered ripple carry between passes.
//   Subtraction is done as A + ~B + ~cin, so cout is the "no borrow" flag.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   operation request, honoured only in IDLE or DONE
//   sub    in   0: A+B+cin   1: A-B-cin (cin is borrow-in)
//   inA    in   operand A, captured on the accepting edge
//   inB    in   operand B, captured on the accepting edge
//   cin    in   carry-in / borrow-in, captured on the accepting edge
//   busy   out  high while nibble passes are running
//   done   out  one-cycle pulse, out/cout/ovf valid
//   out    out  registered result
//   cout   out  raw carry out of the MSB slice
//   ovf    out  two's-complement overflow of the full result
module hc283_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("hc283_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       nib_a, nib_b;
  logic [4:0]       sum;
  logic [3:0]       low3;

  // Shared 4-bit slice: select the active nibble and add it with the carry.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
    sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    // Bit 3 of the low three-bit sum is the carry into the slice MSB,
    // needed for overflow on the final pass.
    low3 = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = inA;
          // Subtract as A + ~B + ~borrow.
          b_d     = sub ? ~inB : inB;
          carry_d = cin ^ sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (k_q == KW'(i)) begin
            out_d[4*i +: 4] = sum[3:0];
          end
        end
        carry_d = sum[4];
        if (k_q == K_LAST) begin
          cout_d  = sum[4];
          ovf_d   = low3[3] ^ sum[4];
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
    // Operand holding registers are only meaningful after a capture.
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_hc283_seq_adder.sv
// tb_hc283_seq_adder
//   Drives three instances (WIDTH = 4, 8, 16) of hc283_seq_adder. Expected
//   results come from an integer-arithmetic reference model and are queued
//   per instance when an operation is issued; a negedge monitor compares
//   busy/done timing and results against the queue heads.
module tb_hc283_seq_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] ia[3], ib[3];
  logic        st[3], sb[3], ci[3];
  logic        bz[3], dn[3], co[3], ov[3];
  logic [3:0]  o4;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [15:0] ow[3];

  assign ow[0] = {12'h000, o4};
  assign ow[1] = {8'h00, o8};
  assign ow[2] = o16;

  hc283_seq_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]),
    .inA(ia[0][3:0]), .inB(ib[0][3:0]), .cin(ci[0]),
    .busy(bz[0]), .done(dn[0]), .out(o4), .cout(co[0]), .ovf(ov[0]));

  hc283_seq_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]),
    .inA(ia[1][7:0]), .inB(ib[1][7:0]), .cin(ci[1]),
    .busy(bz[1]), .done(dn[1]), .out(o8), .cout(co[1]), .ovf(ov[1]));

  hc283_seq_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]),
    .inA(ia[2]), .inB(ib[2]), .cin(ci[2]),
    .busy(bz[2]), .done(dn[2]), .out(o16), .cout(co[2]), .ovf(ov[2]));

  typedef struct {
    logic [15:0] o;
    logic        c;
    logic        v;
    int          acc;   // edge number that accepts the operation
    int          dcyc;  // cycle count at which done must be high
  } exp_t;

  exp_t        sbq[3][$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [15:0] last_o[3];
  logic        last_c[3], last_v[3];
  int          next_ok[3];

  function automatic int nsl(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c, output exp_t e);
    longint m, h, ua, ub, sa, sbv, u, r, lc;
    m   = longint'(1) << (4 * nsl(i));
    h   = m / 2;
    ua  = longint'(a) & (m - 1);
    ub  = longint'(b) & (m - 1);
    sa  = (ua >= h) ? ua - m : ua;
    sbv = (ub >= h) ? ub - m : ub;
    lc  = c ? 1 : 0;
    if (!s) begin
      u   = ua + ub + lc;
      r   = sa + sbv + lc;
      e.c = (u >= m);
    end else begin
      u   = ua - ub - lc;
      r   = sa - sbv - lc;
      e.c = (ua >= ub + lc);
    end
    e.o   = 16'(u & (m - 1));
    e.v   = (r < -h) || (r >= h);
    e.acc = 0;
    e.dcyc = 0;
  endtask

  // Issue one operation. While the instance is still busy, start is held
  // high with scrambled operands, which the DUT must ignore.
  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c);
    exp_t e;
    @(negedge clk);
    while (cyc + 1 < next_ok[i]) begin
      st[i] = 1'b1;
      ia[i] = 16'($urandom);
      ib[i] = 16'($urandom);
      sb[i] = 1'($urandom);
      ci[i] = 1'($urandom);
      @(negedge clk);
    end
    ia[i] = a; ib[i] = b; sb[i] = s; ci[i] = c; st[i] = 1'b1;
    model(i, a, b, s, c, e);
    e.acc  = cyc + 1;
    e.dcyc = cyc + 1 + nsl(i);
    sbq[i].push_back(e);
    next_ok[i] = e.dcyc + 1;
    @(posedge clk);
    #1;
    ia[i] = 16'($urandom);
    ib[i] = 16'($urandom);
    sb[i] = 1'($urandom);
    ci[i] = 1'($urandom);
  endtask

  task automatic release_start(input int i);
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!dn[i] && g < 20);
    if (!dn[i]) check1("done_timeout", dn[i], 1'b1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (n) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      sbq[i].delete();
      last_o[i] = '0; last_c[i] = 1'b0; last_v[i] = 1'b0;
      next_ok[i] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: busy/done timing against queued operations, results on done,
  // and held outputs while idle.
  always @(negedge clk) begin
    exp_t e;
    bit   act;
    if (mon_en && !rst) begin
      for (int i = 0; i < 3; i++) begin
        act = (sbq[i].size() > 0) && (sbq[i][0].acc <= cyc);
        if (!act) begin
          check1("idle_busy", bz[i], 1'b0);
          check1("idle_done", dn[i], 1'b0);
          check16("hold_out", ow[i], last_o[i]);
          check1("hold_cout", co[i], last_c[i]);
          check1("hold_ovf", ov[i], last_v[i]);
        end else begin
          e = sbq[i][0];
          if (cyc < e.dcyc) begin
            check1("run_busy", bz[i], 1'b1);
            check1("run_done", dn[i], 1'b0);
          end else begin
            check1("done_pulse", dn[i], 1'b1);
            check1("done_busy", bz[i], 1'b0);
            check16("res_out", ow[i], e.o);
            check1("res_cout", co[i], e.c);
            check1("res_ovf", ov[i], e.v);
            last_o[i] = e.o; last_c[i] = e.c; last_v[i] = e.v;
            void'(sbq[i].pop_front());
          end
        end
      end
    end
  end

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int g;
    bit empty;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; sb[i] = 1'b0; ci[i] = 1'b0; ia[i] = '0; ib[i] = '0;
      next_ok[i] = 0;
    end
    do_reset(3);

    // Reset state of all instances.
    for (int i = 0; i < 3; i++) begin
      check1("rst_busy", bz[i], 1'b0);
      check1("rst_done", dn[i], 1'b0);
      check16("rst_out", ow[i], 16'h0000);
      check1("rst_cout", co[i], 1'b0);
      check1("rst_ovf", ov[i], 1'b0);
    end
    mon_en = 1'b1;

    // WIDTH=4 directed cases.
    issue(0, 16'h0007, 16'h0005, 1'b0, 1'b1);
    release_start(0);
    wait_done(0);
    check16("t1_out", ow[0], 16'h000D);
    check1("t1_cout", co[0], 1'b0);
    check1("t1_ovf", ov[0], 1'b1);

    issue(0, 16'h000D, 16'h0009, 1'b0, 1'b0);
    release_start(0);
    wait_done(0);
    check16("t2_out", ow[0], 16'h0006);
    check1("t2_cout", co[0], 1'b1);
    check1("t2_ovf", ov[0], 1'b1);

    // WIDTH=8 subtraction.
    issue(1, 16'h0030, 16'h0045, 1'b1, 1'b0);
    release_start(1);
    wait_done(1);
    check16("t3a_out", ow[1], 16'h00EB);
    check1("t3a_cout", co[1], 1'b0);
    check1("t3a_ovf", ov[1], 1'b0);

    issue(1, 16'h0045, 16'h0030, 1'b1, 1'b0);
    release_start(1);
    wait_done(1);
    check16("t3b_out", ow[1], 16'h0015);
    check1("t3b_cout", co[1], 1'b1);
    check1("t3b_ovf", ov[1], 1'b0);

    // WIDTH=16 full ripple and signed overflow.
    issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    release_start(2);
    wait_done(2);
    check16("t4a_out", ow[2], 16'h0000);
    check1("t4a_cout", co[2], 1'b1);
    check1("t4a_ovf", ov[2], 1'b0);

    issue(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    release_start(2);
    wait_done(2);
    check16("t4b_out", ow[2], 16'h8000);
    check1("t4b_cout", co[2], 1'b0);
    check1("t4b_ovf", ov[2], 1'b1);

    // Back-to-back with start held high (including through RUN).
    for (int n = 0; n < 8; n++)
      issue(2, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
    release_start(2);
    repeat (6) @(negedge clk);

    // Randomized mix over all widths, from IDLE and from DONE.
    for (int n = 0; n < 60; n++) begin
      int i;
      i = $urandom_range(0, 2);
      issue(i, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
      release_start(i);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(nsl(i), nsl(i) + 3)) @(negedge clk);
      end
    end
    repeat (8) @(negedge clk);

    // Reset during the second RUN cycle of a WIDTH=16 operation.
    issue(2, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    do_reset(1);
    check1("mrst_busy", bz[2], 1'b0);
    check1("mrst_done", dn[2], 1'b0);
    check16("mrst_out", ow[2], 16'h0000);
    check1("mrst_cout", co[2], 1'b0);
    check1("mrst_ovf", ov[2], 1'b0);
    repeat (6) @(negedge clk);

    // Fresh operation after the abort.
    issue(2, 16'h1234, 16'h4321, 1'b0, 1'b1);
    release_start(2);
    wait_done(2);
    check16("post_out", ow[2], 16'h5556);
    check1("post_cout", co[2], 1'b0);
    check1("post_ovf", ov[2], 1'b0);

    // Drain all outstanding expectations within a bounded time.
    g = 0;
    do begin
      @(negedge clk);
      g++;
      empty = (sbq[0].size() == 0) && (sbq[1].size() == 0) && (sbq[2].size() == 0);
    end while (!empty && g < 200);
    check1("drain", empty, 1'b1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hc283_seq_adder.md
Name: hc283_seq_adder

Overview:
Parametrised successor to the 4-bit 74HC283 full-adder block. Adds or subtracts two WIDTH-bit operands by reusing a single 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. A registered ripple carry links the nibbles. A start/busy/done handshake lets a sequencer issue back-to-back operations. The block sits in the 74hc00 arithmetic library as the multi-cycle, area-cheap wide adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived (localparam): number of nibble passes; also the operation latency in cycles

Ports:
clk     input   1       rising-edge clock
rst     input   1       synchronous reset, active-high
start   input   1       operation request; sampled only when idle or in DONE
sub     input   1       0 = A+B+cin; 1 = A-B-cin (cin acts as borrow-in)
inA     input   WIDTH   operand A; captured on the accepting edge
inB     input   WIDTH   operand B; captured on the accepting edge
cin     input   1       carry-in (add) / borrow-in (sub); captured on the accepting edge
busy    output  1       high while nibble passes are in progress
done    output  1       one-cycle pulse: out/cout/ovf are valid
out     output  WIDTH   result, registered
cout    output  1       raw carry out of the MSB slice
ovf     output  1       two's-complement overflow of the full WIDTH result

Behaviour:
- States: IDLE, RUN, DONE. Slice index k is a counter of clog2(NSLICE) bits, minimum 1 bit.
- Reset (rst=1 at an edge, in any state, including mid-RUN): state=IDLE, k=0, busy=0, done=0, out=0, cout=0, ovf=0, internal carry=0. The aborted operation is discarded and no done pulse is issued.
- IDLE or DONE with start=1 at edge E0: capture A=inA.
  - Capture B=inB when sub=0, or B=~inB when sub=1.
  - Set carry=cin when sub=0, or carry=~cin when sub=1.
  - Set k=0 and go to RUN.
- Operands are held internally. inA, inB, cin and sub may change after E0 without effect.
- RUN, at each edge E1..ENSLICE:
  - Combinationally sum = A[4k+3:4k] + B[4k+3:4k] + carry (5 bits).
  - Register out[4k+3:4k] = sum[3:0] and carry = sum[4].
  - Nibbles of out not yet written keep their previous value until overwritten.
- At edge ENSLICE (k = NSLICE-1):
  - cout = sum[4].
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, taken from inside the final slice.
  - state=DONE.
  - Otherwise k increments.
- busy = (state==RUN). done = (state==DONE). Both are registered state decodes, with no combinational path from start.
- Latency: done is high in the cycle immediately after edge ENSLICE, i.e. NSLICE cycles after the accepting edge. With WIDTH=4, done follows one cycle after start.
- DONE lasts exactly one cycle:
  - start=1 starts a new operation (back-to-back throughput of one operation per NSLICE+1 cycles).
  - Otherwise the block returns to IDLE.
- out, cout and ovf hold their values after DONE until the next operation's first nibble write.
- start during RUN is ignored. It is neither queued nor does it disturb the current operation.
- Subtraction: cout=1 means no borrow and cout=0 means a borrow occurred. cout is not inverted.
- Simultaneous rst and start: reset wins and the block stays IDLE.

Test Plan:
1. WIDTH=4, sub=0, inA=0111, inB=0101, cin=1, start pulse -> busy for 1 cycle, then done; out=1101, cout=0, ovf=1.
2. WIDTH=4, inA=1101, inB=1001, cin=0 -> out=0110, cout=1, ovf=1.
3. WIDTH=8, sub=1, inA=0x30, inB=0x45, cin=0 -> busy 2 cycles; done on cycle 2 after the accepting edge; out=0xEB, cout=0, ovf=0. Repeat with inA=0x45, inB=0x30 -> out=0x15, cout=1.
4. WIDTH=16, inA=0xFFFF, inB=0x0001, cin=0 -> carry ripples through all 4 slices; out=0x0000, cout=1, ovf=0. inA=0x7FFF, inB=0x0001 -> out=0x8000, ovf=1.
5. WIDTH=16, start held high continuously with new operands each DONE cycle -> done pulses every 5 cycles and each result is correct. A start pulse mid-RUN has no effect on the result or on timing.
6. WIDTH=16, assert rst for one cycle at the second RUN cycle -> next cycle busy=0, done=0, out=0, and no done pulse. A fresh start afterwards computes correctly.
